fetch_sequencer: RTL and testbench

- Top-level instruction-cycle controller for the image-downsampling processor.
- Sequences the program counter with PCI/BRANCH/branch-target, strobes instruction memory and the instruction register, and hands execution off to the datapath through a start/done handshake.
- Owns jump, conditional jump (zero flag), call/return through an internal return-address stack, and program end/halt.
- Sits between the decoder/datapath and the PC, instruction memory and IR.

---
 rtl/fetch_sequencer_pkg.sv | 29 ++
 rtl/fetch_sequencer_if.sv | 45 ++++
 rtl/fetch_sequencer_ras_stack.sv | 48 ++++
 rtl/fetch_sequencer.sv | 201 ++++++++++++++++++++
 tb/tb_fetch_sequencer.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_sequencer_pkg.sv
// Shared types and constants for the instruction-cycle controller.
// No logic; enums, defaults and next-PC action codes only.
// Imported by the interface, the top level and its bench.
package fseq_pkg;

    // Default PC / instruction-address width.
    localparam int FSEQ_AW_DEF = 8;

    // Controller states; one instruction walks FETCH..NEXT.
    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_LOAD,
        S_DECODE,
        S_EXEC,
        S_WAIT_EXEC,
        S_NEXT,
        S_HALT
    } fseq_state_e;

    // What the PC should do in the NEXT cycle.
    typedef enum logic [1:0] {
        ACT_NONE,
        ACT_INC,
        ACT_LOAD
    } next_act_e;

endpackage

// File: rtl/fetch_sequencer_if.sv
// Bundle between the sequencer and its decoder, datapath, PC, IMEM and IR.
// Master is the sequencer; slave is the surrounding processor.
// Pure level/pulse signalling; no backpressure beyond start/exec_done.
interface fetch_sequencer_if
    import fseq_pkg::*;
#(
    parameter int AW = FSEQ_AW_DEF
) ();

    logic          start;
    logic [AW-1:0] pc_addr;
    logic          dec_jmp;
    logic          dec_jmpz;
    logic          dec_call;
    logic          dec_ret;
    logic          dec_end;
    logic [AW-1:0] dec_target;
    logic          z_flag;
    logic          exec_done;

    logic          PCI;
    logic          BRANCH;
    logic [AW-1:0] addr_in;
    logic          imem_re;
    logic          ir_load;
    logic          exec_start;
    logic          running;
    logic          halted;
    logic          ras_err;

    modport master (
        input  start, pc_addr, dec_jmp, dec_jmpz, dec_call, dec_ret, dec_end,
               dec_target, z_flag, exec_done,
        output PCI, BRANCH, addr_in, imem_re, ir_load, exec_start,
               running, halted, ras_err
    );

    modport slave (
        output start, pc_addr, dec_jmp, dec_jmpz, dec_call, dec_ret, dec_end,
               dec_target, z_flag, exec_done,
        input  PCI, BRANCH, addr_in, imem_re, ir_load, exec_start,
               running, halted, ras_err
    );

endinterface

// File: rtl/fetch_sequencer_ras_stack.sv
// Return-address LIFO, DEPTH entries of AW bits; top is the last push.
// Push/pop take effect on the clock edge; top/full/empty are combinational.
// Push when full and pop when empty are ignored; caller decides the error.
module ras_stack #(
    parameter int DEPTH = 4,
    parameter int AW    = 8
) (
    input  logic          clk,
    input  logic          RST,
    input  logic          i_push,
    input  logic          i_pop,
    input  logic [AW-1:0] i_dat,
    output logic [AW-1:0] o_top,
    output logic          o_full,
    output logic          o_empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW:0] FULL_CNT = DEPTH[PW:0];

    logic [PW:0]   r_sp;
    logic [AW-1:0] r_mem [DEPTH];
    logic [PW-1:0] w_top_idx;

    assign o_full    = (r_sp == FULL_CNT);
    assign o_empty   = (r_sp == '0);
    assign w_top_idx = r_sp[PW-1:0] - 1'b1;
    assign o_top     = r_mem[w_top_idx];

    // Stack pointer: counts valid entries, cleared by reset.
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            r_sp <= '0;
        end else if (i_push && !o_full) begin
            r_sp <= r_sp + 1'b1;
        end else if (i_pop && !o_empty) begin
            r_sp <= r_sp - 1'b1;
        end
    end

    // Storage: write the pushed address at the current pointer slot.
    always_ff @(posedge clk) begin
        if (i_push && !o_full) begin
            r_mem[r_sp[PW-1:0]] <= i_dat;
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-cycle controller: fetch, IR load, decode, exec handshake, PC step.
// Plain instr = 5 + exec wait cycles (6 with immediate exec_done); branch = 4.
// Stalls only in WAIT_EXEC until exec_done; all outputs are registered state decodes.
module fetch_sequencer
    import fseq_pkg::*;
#(
    parameter int AW        = FSEQ_AW_DEF,
    parameter int IMEM_LAT  = 1,
    parameter int RAS_DEPTH = 4
) (
    input  logic              clk,
    input  logic              RST,
    fetch_sequencer_if.master bus
);

    localparam int CW = (IMEM_LAT > 2) ? $clog2(IMEM_LAT) : 1;
    localparam logic [CW-1:0] WAIT_INIT = CW'((IMEM_LAT > 1) ? (IMEM_LAT - 2) : 0);

    fseq_state_e   r_state;
    logic          r_pci;
    logic          r_branch;
    logic [AW-1:0] r_addr_in;
    logic          r_imem_re;
    logic          r_ir_load;
    logic          r_exec_start;
    logic          r_running;
    logic          r_halted;
    logic          r_ras_err;
    logic [AW-1:0] r_pc_q;
    logic [CW-1:0] r_wcnt;

    next_act_e     w_act;
    logic [AW-1:0] w_tgt;
    logic          w_halt;
    logic          w_err;
    logic          w_push;
    logic          w_pop;
    logic [AW-1:0] w_top;
    logic [AW-1:0] w_ret_addr;
    logic          w_full;
    logic          w_empty;

    // Return address is the instruction after the call; wraps naturally.
    assign w_ret_addr = r_pc_q + AW'(1);

    ras_stack #(
        .DEPTH (RAS_DEPTH),
        .AW    (AW)
    ) u_ras (
        .clk     (clk),
        .RST     (RST),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_dat   (w_ret_addr),
        .o_top   (w_top),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Decode resolution in DECODE: end > ret > call > jmp > jmpz, else execute.
    always_comb begin
        w_act  = ACT_NONE;
        w_tgt  = bus.dec_target;
        w_halt = 1'b0;
        w_err  = 1'b0;
        w_push = 1'b0;
        w_pop  = 1'b0;
        if (r_state == S_DECODE) begin
            if (bus.dec_end) begin
                w_halt = 1'b1;
            end else if (bus.dec_ret) begin
                if (w_empty) begin
                    w_halt = 1'b1;
                    w_err  = 1'b1;
                end else begin
                    w_pop = 1'b1;
                    w_act = ACT_LOAD;
                    w_tgt = w_top;
                end
            end else if (bus.dec_call) begin
                if (w_full) begin
                    w_halt = 1'b1;
                    w_err  = 1'b1;
                end else begin
                    w_push = 1'b1;
                    w_act  = ACT_LOAD;
                end
            end else if (bus.dec_jmp) begin
                w_act = ACT_LOAD;
            end else if (bus.dec_jmpz) begin
                w_act = bus.z_flag ? ACT_LOAD : ACT_INC;
            end
        end
    end

    // Main FSM: next state plus registered Moore outputs for the state entered.
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            r_state      <= S_IDLE;
            r_pci        <= 1'b0;
            r_branch     <= 1'b0;
            r_addr_in    <= '0;
            r_imem_re    <= 1'b0;
            r_ir_load    <= 1'b0;
            r_exec_start <= 1'b0;
            r_running    <= 1'b0;
            r_halted     <= 1'b0;
            r_ras_err    <= 1'b0;
            r_pc_q       <= '0;
            r_wcnt       <= '0;
        end else begin
            r_pci        <= 1'b0;
            r_branch     <= 1'b0;
            r_addr_in    <= '0;
            r_imem_re    <= 1'b0;
            r_ir_load    <= 1'b0;
            r_exec_start <= 1'b0;
            r_running    <= 1'b1;
            r_halted     <= 1'b0;
            r_ras_err    <= r_ras_err | w_err;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_state   <= S_FETCH;
                        r_imem_re <= 1'b1;
                    end else begin
                        r_running <= 1'b0;
                    end
                end
                S_FETCH: begin
                    r_pc_q <= bus.pc_addr;
                    if (IMEM_LAT == 1) begin
                        r_state   <= S_LOAD;
                        r_ir_load <= 1'b1;
                    end else begin
                        r_state <= S_WAIT;
                        r_wcnt  <= WAIT_INIT;
                    end
                end
                S_WAIT: begin
                    if (r_wcnt == '0) begin
                        r_state   <= S_LOAD;
                        r_ir_load <= 1'b1;
                    end else begin
                        r_wcnt <= r_wcnt - 1'b1;
                    end
                end
                S_LOAD: begin
                    r_state <= S_DECODE;
                end
                S_DECODE: begin
                    if (w_halt) begin
                        r_state   <= S_HALT;
                        r_running <= 1'b0;
                        r_halted  <= 1'b1;
                    end else if (w_act == ACT_NONE) begin
                        r_state      <= S_EXEC;
                        r_exec_start <= 1'b1;
                    end else begin
                        r_state   <= S_NEXT;
                        r_pci     <= (w_act == ACT_INC);
                        r_branch  <= (w_act == ACT_LOAD);
                        r_addr_in <= (w_act == ACT_LOAD) ? w_tgt : '0;
                    end
                end
                S_EXEC: begin
                    r_state <= S_WAIT_EXEC;
                end
                S_WAIT_EXEC: begin
                    if (bus.exec_done) begin
                        r_state <= S_NEXT;
                        r_pci   <= 1'b1;
                    end
                end
                S_NEXT: begin
                    r_state   <= S_FETCH;
                    r_imem_re <= 1'b1;
                end
                S_HALT: begin
                    r_running <= 1'b0;
                    r_halted  <= 1'b1;
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_running <= 1'b0;
                end
            endcase
        end
    end

    assign bus.PCI        = r_pci;
    assign bus.BRANCH     = r_branch;
    assign bus.addr_in    = r_addr_in;
    assign bus.imem_re    = r_imem_re;
    assign bus.ir_load    = r_ir_load;
    assign bus.exec_start = r_exec_start;
    assign bus.running    = r_running;
    assign bus.halted     = r_halted;
    assign bus.ras_err    = r_ras_err;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: program table + PC model drive the decoder inputs,
// an instruction-level reference model predicts each instruction's cycle cost,
// PC effect, exec handshake, stack behaviour and halt/error outcome.
module tb_fetch_sequencer;

    localparam int K_PLAIN  = 0;
    localparam int K_JMP    = 1;
    localparam int K_JMPZ   = 2;
    localparam int K_CALL   = 3;
    localparam int K_RET    = 4;
    localparam int K_END    = 5;
    localparam int K_ENDJMP = 6;
    localparam int DEPTH    = 4;

    logic clk = 1'b0;
    logic RST;
    always #5 clk = ~clk;

    fetch_sequencer_if #(.AW(8)) bus ();

    fetch_sequencer #(
        .AW        (8),
        .IMEM_LAT  (1),
        .RAS_DEPTH (DEPTH)
    ) dut (
        .clk (clk),
        .RST (RST),
        .bus (bus)
    );

    int         p_kind [256];
    logic [7:0] p_tgt  [256];
    logic       p_z    [256];

    logic [7:0] pc;
    int         cur_dly;
    int         done_cnt;
    logic       noise;

    int n_chk = 0;
    int n_err = 0;

    logic [7:0] m_stk [$];
    logic       m_err;

    // Environment PC: increments on PCI, loads on BRANCH.
    always @(posedge clk or posedge RST) begin
        if (RST) pc <= 8'h00;
        else if (bus.PCI) pc <= pc + 8'd1;
        else if (bus.BRANCH) pc <= bus.addr_in;
    end

    // Datapath stand-in: exec_done cur_dly cycles after exec_start.
    always @(posedge clk or posedge RST) begin
        if (RST) done_cnt <= 0;
        else if (bus.exec_start) done_cnt <= cur_dly;
        else if (done_cnt > 0) done_cnt <= done_cnt - 1;
    end

    assign bus.pc_addr    = pc;
    assign bus.dec_jmp    = (p_kind[pc] == K_JMP) || (p_kind[pc] == K_ENDJMP);
    assign bus.dec_jmpz   = (p_kind[pc] == K_JMPZ);
    assign bus.dec_call   = (p_kind[pc] == K_CALL);
    assign bus.dec_ret    = (p_kind[pc] == K_RET);
    assign bus.dec_end    = (p_kind[pc] == K_END) || (p_kind[pc] == K_ENDJMP);
    assign bus.dec_target = p_tgt[pc];
    assign bus.z_flag     = p_z[pc];
    // A spurious done during exec_start must be ignored by the DUT.
    assign bus.exec_done  = (done_cnt == 1) || (bus.exec_start && noise);

    function automatic logic [15:0] outs();
        return {bus.PCI, bus.BRANCH, bus.addr_in, bus.imem_re, bus.ir_load,
                bus.exec_start, bus.running, bus.halted, bus.ras_err};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_prog();
        for (int i = 0; i < 256; i++) begin
            p_kind[i] = K_PLAIN;
            p_tgt[i]  = 8'h00;
            p_z[i]    = 1'b0;
        end
    endtask

    task automatic wait_fetch(input string tag);
        int k = 0;
        while (bus.imem_re !== 1'b1 && k < 8) begin
            @(negedge clk);
            k++;
        end
        chk(tag, bus.imem_re, 1);
    endtask

    // Reset, check idle outputs, start and arrive at the first fetch of pc 0.
    task automatic go(input string tag);
        bus.start = 1'b0;
        RST = 1'b1;
        m_stk.delete();
        m_err = 1'b0;
        @(negedge clk);
        chk({tag, "_rst_outs"}, 32'(outs()), 0);
        RST = 1'b0;
        bus.start = 1'b1;
        wait_fetch({tag, "_first_fetch"});
        chk({tag, "_first_pc"}, 32'(pc), 0);
    endtask

    // Run one instruction from its fetch cycle and compare with the model.
    task automatic step(input string tag, input int dly, output logic hlt);
        logic [7:0] pc0, e_addr, e_next, br_addr, ra;
        logic e_br, e_pci, e_exec, e_halt;
        int kind, e_len, cyc, n_exec, n_pci, n_br, n_ir, n_both, n_idle;
        pc0 = pc;
        cur_dly = dly;
        noise = 1'($urandom_range(0, 1));
        e_br = 0; e_pci = 0; e_exec = 0; e_halt = 0; e_addr = 8'h00;
        kind = p_kind[pc0];
        case (kind)
            K_END, K_ENDJMP: e_halt = 1;
            K_RET: begin
                if (m_stk.size() == 0) begin e_halt = 1; m_err = 1; end
                else begin e_br = 1; e_addr = m_stk.pop_back(); end
            end
            K_CALL: begin
                if (m_stk.size() == DEPTH) begin e_halt = 1; m_err = 1; end
                else begin
                    ra = pc0 + 8'd1;
                    m_stk.push_back(ra);
                    e_br = 1; e_addr = p_tgt[pc0];
                end
            end
            K_JMP: begin e_br = 1; e_addr = p_tgt[pc0]; end
            K_JMPZ: begin
                if (p_z[pc0]) begin e_br = 1; e_addr = p_tgt[pc0]; end
                else e_pci = 1;
            end
            default: begin e_exec = 1; e_pci = 1; end
        endcase
        e_len  = e_halt ? 3 : (e_exec ? 5 + dly : 4);
        e_next = e_br ? e_addr : pc0 + 8'd1;

        cyc = 0; n_exec = 0; n_pci = 0; n_br = 0; n_ir = 0; n_both = 0; n_idle = 0;
        br_addr = 8'h00;
        do begin
            @(negedge clk);
            cyc++;
            if (bus.exec_start) n_exec++;
            if (bus.PCI) n_pci++;
            if (bus.BRANCH) begin n_br++; br_addr = bus.addr_in; end
            if (bus.ir_load) n_ir++;
            if (bus.PCI && bus.BRANCH) n_both++;
            if (!bus.running && !bus.halted) n_idle++;
        end while (!bus.imem_re && !bus.halted && cyc < 200);

        chk({tag, "_cycles"}, cyc, e_len);
        chk({tag, "_ir_load"}, n_ir, 1);
        chk({tag, "_exec_start"}, n_exec, e_exec);
        chk({tag, "_pci"}, n_pci, e_pci);
        chk({tag, "_branch"}, n_br, e_br);
        chk({tag, "_pci_and_branch"}, n_both, 0);
        chk({tag, "_running"}, n_idle, 0);
        chk({tag, "_halted"}, bus.halted, e_halt);
        chk({tag, "_ras_err"}, bus.ras_err, m_err);
        if (e_br) chk({tag, "_addr_in"}, br_addr, e_addr);
        if (!e_halt) chk({tag, "_next_pc"}, pc, e_next);
        hlt = bus.halted | (cyc >= 200);
    endtask

    // Toggle start while halted; no fetch may occur.
    task automatic halt_hold(input string tag);
        int n_re = 0;
        for (int i = 0; i < 8; i++) begin
            bus.start = ~bus.start;
            @(negedge clk);
            if (bus.imem_re) n_re++;
        end
        chk({tag, "_no_fetch"}, n_re, 0);
        chk({tag, "_still_halted"}, bus.halted, 1);
        chk({tag, "_err_sticky"}, bus.ras_err, m_err);
    endtask

    initial begin
        logic h;
        int   k, r;
        RST = 1'b1;
        bus.start = 1'b0;
        cur_dly = 1;
        noise = 1'b0;
        m_err = 1'b0;
        clear_prog();

        // Plain instructions: delayed and immediate exec_done.
        go("plain");
        step("plain_d3", 3, h);
        step("plain_d1", 1, h);

        // Asynchronous reset while waiting on the datapath.
        cur_dly = 40;
        k = 0;
        while (!bus.exec_start && k < 20) begin @(negedge clk); k++; end
        chk("rstmid_exec_seen", bus.exec_start, 1);
        @(negedge clk);
        @(negedge clk);
        chk("rstmid_running", bus.running, 1);
        #2 RST = 1'b1;
        #1 chk("rstmid_outs_zero", 32'(outs()), 0);
        m_stk.delete();
        m_err = 1'b0;
        @(negedge clk);
        RST = 1'b0;
        bus.start = 1'b1;
        wait_fetch("rstmid_refetch");
        chk("rstmid_pc0", pc, 0);
        step("rstmid_after", 1, h);

        // Conditional jump, taken then not taken.
        clear_prog();
        p_kind[0] = K_JMPZ; p_tgt[0] = 8'h40; p_z[0] = 1'b1;
        p_kind[8'h40] = K_JMPZ; p_tgt[8'h40] = 8'h40; p_z[8'h40] = 1'b0;
        go("jmpz");
        step("jmpz_taken", 1, h);
        step("jmpz_not", 1, h);

        // Call/return, including return-address wrap past 0xFF.
        clear_prog();
        p_kind[0] = K_JMP; p_tgt[0] = 8'h10;
        p_kind[8'h10] = K_CALL; p_tgt[8'h10] = 8'h80;
        p_kind[8'h80] = K_RET;
        p_kind[8'h11] = K_JMP; p_tgt[8'h11] = 8'hFF;
        p_kind[8'hFF] = K_CALL; p_tgt[8'hFF] = 8'h20;
        p_kind[8'h20] = K_RET;
        go("callret");
        step("cr_jmp", 1, h);
        step("cr_call", 1, h);
        step("cr_ret", 1, h);
        step("cr_jmpff", 1, h);
        step("cr_callff", 1, h);
        step("cr_retwrap", 1, h);

        // Five nested calls overflow a four-entry stack.
        clear_prog();
        for (int i = 0; i < 5; i++) begin
            p_kind[i] = K_CALL;
            p_tgt[i]  = 8'(i + 1);
        end
        go("nest");
        for (int i = 0; i < 5; i++) step($sformatf("nest_call%0d", i), 1, h);
        halt_hold("nest_hold");

        // Return with an empty stack.
        clear_prog();
        p_kind[0] = K_RET;
        go("empty_ret");
        step("empty_ret", 1, h);
        halt_hold("empty_ret_hold");

        // End wins over a simultaneous jump.
        clear_prog();
        p_kind[0] = K_ENDJMP; p_tgt[0] = 8'h33;
        go("endjmp");
        step("endjmp", 1, h);
        halt_hold("endjmp_hold");

        // Random programs against the instruction-level model.
        for (int run = 0; run < 25; run++) begin
            for (int i = 0; i < 256; i++) begin
                r = $urandom_range(0, 99);
                p_kind[i] = (r < 35) ? K_PLAIN : (r < 50) ? K_JMP : (r < 65) ? K_JMPZ :
                            (r < 80) ? K_CALL : (r < 96) ? K_RET : K_END;
                p_tgt[i] = 8'($urandom_range(0, 255));
                p_z[i]   = 1'($urandom_range(0, 1));
            end
            go($sformatf("rnd%0d", run));
            h = 1'b0;
            for (int j = 0; j < 40 && !h; j++) begin
                step($sformatf("rnd%0d_i%0d", run, j), int'($urandom_range(1, 4)), h);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
